regfile_burst_reader: RTL
=========================

# regfile_burst_reader

Read-side burst engine for the 32×32 register file. It accepts a request for `len` consecutive registers starting at `addr`, drives the file's combinational read address, and streams the captured words out on a valid/ready interface with a last-beat marker. It sits between the register file read port and any consumer that needs bulk readback, such as a debug dump, a context save, or the testbench scoreboard.

## Interface
- `WIDTH`, default 32: data word width.
- `ADDR_W`, default 5: register address width; depth is 2^ADDR_W.
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `req_valid`, in, 1: a burst request is present.
- `req_ready`, out, 1: the engine can accept a request.
- `req_addr`, in, ADDR_W: first register to read.
- `req_len`, in, ADDR_W+1: beat count, 1..32. A value of 0 is a legal no-op.
- `rf_addr`, out, ADDR_W: read address to the register file.
- `rf_data`, in, WIDTH: combinational read data for `rf_addr`.
- `out_valid`, out, 1: `out_data` is valid.
- `out_ready`, in, 1: the consumer accepts the beat.
- `out_data`, out, WIDTH: captured register word.
- `out_idx`, out, ADDR_W: address the beat was read from.
- `out_last`, out, 1: final beat of the burst.
- `busy`, out, 1: a burst is in progress.

## Operation
**States**
- **IDLE**
  - `req_ready` = 1.
  - When `req_valid` is high: latch `cur` = `req_addr` and `rem` = `req_len`, then go to RUN.
  - If `req_len` = 0: stay in IDLE, emit no beats, and hold `req_ready` high.
- **RUN**
  - `rf_addr` = `cur`.
  - Capture condition: the output register is empty, or `out_ready` is high.
  - On capture: `out_data` ← `rf_data`, `out_idx` ← `cur`, `out_last` ← (`rem` == 1), `cur` ← `cur`+1 modulo 2^ADDR_W, `rem` ← `rem`−1.
  - After the capture with `rem` == 1, go to DRAIN.
- **DRAIN**
  - Hold the last beat.
  - When `out_valid` and `out_ready` are both high, go to IDLE.

**Rules**
- `busy` = 1 in RUN and DRAIN.
- `req_ready` = 0 in RUN and DRAIN.
- Address wrap-around: `cur` wraps 31→0 with no error. A 32-beat burst starting at 31 reads 31, 0, 1, …, 30.
- Backpressure: while `out_valid` is high and `out_ready` is low, `out_data`, `out_idx` and `out_last` hold stable. `cur` and `rem` do not advance.
- The output register is cleared when its beat is accepted and no new capture happens in the same cycle.
- `rf_addr` in IDLE drives `req_addr`; the value is don't-care for correctness.
- Read/write collision: a write to the same register on the capture edge is not seen. The beat carries the pre-write value.
- `rst_n` low at any time, including mid-burst:
  - Go to IDLE immediately.
  - `out_valid`, `out_last` and `busy` = 0.
  - `out_data` and `out_idx` = 0.
  - `cur` and `rem` = 0.
  - `req_ready` = 1 once reset is released.
  - An in-flight burst is discarded and not resumed.

## Timing
- Request accepted at edge E0. The first beat is captured at E1 and `out_valid` is high after E1.
- With `out_ready` held high, a burst of N beats completes with its last handshake at edge E(N+1).
- The next request can be accepted at E(N+1)+1. There is no back-to-back request overlap.
- Throughput is 1 beat per cycle with no bubbles under continuous `out_ready`.
- A stall of k cycles adds exactly k cycles to completion.
- All outputs are registered except `req_ready`, `busy` and `rf_addr`. Those three are decoded from state and `cur`.

## Structure
- Shared package `regfile_pkg` holds:
  - `WIDTH` and `ADDR_W` constants.
  - The state enum (IDLE, RUN, DRAIN).
  - The length type (ADDR_W+1 bits).
- One sub-module, `stream_out_stage`, holds the data/idx/last/valid holding register. It has a load input and a clear-on-accept input, shared with future read-side streamers.
- The top level holds the FSM plus the `cur` and `rem` counters.

## Test plan
- **Basic burst:** preload rf[i] = 0xA000_0000+i; request addr=4, len=3, `out_ready`=1.
  - Beats 0xA000_0004, _05, _06 are accepted on consecutive cycles, with `out_idx` 4, 5, 6.
  - `out_last` is high only on the third beat, and `busy` falls the cycle after it.
- **Wrap-around:** request addr=30, len=4.
  - `out_idx` sequence is 30, 31, 0, 1, with data matching.
- **Backpressure:** request addr=0, len=5; hold `out_ready` low for 3 cycles after beat 1 is presented.
  - Beat 1 is held stable for 4 cycles and no beat is lost or duplicated.
  - The burst completes 3 cycles later than the unstalled case.
- **Zero length and full length:**
  - len=0: no `out_valid`, and `req_ready` stays high.
  - len=32 from addr=7: exactly 32 beats, with the last beat at `out_idx` 6.
- **Collision:** rf[9] = 0x1111. A write of 0x2222 to rf[9] lands on the same edge as the capture of beat `out_idx`=9.
  - That beat reports 0x1111.
  - A subsequent burst reads 0x2222.
- **Mid-burst reset:** assert `rst_n`=0 during beat 2 of a len=8 burst.
  - `out_valid`, `busy` and `out_data` go to 0 immediately.
  - After release, `req_ready`=1, and a new request addr=1, len=1 returns rf[1].

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file read-side streamers.
package regfile_pkg;

    localparam int WIDTH  = 32;
    localparam int ADDR_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    typedef logic [ADDR_W:0]   len_t;
    typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/regfile_burst_reader_if.sv
// Request, register-file read port and output stream of the burst reader.
interface regfile_burst_reader_if
    import regfile_pkg::*;
#(
    parameter int WIDTH  = regfile_pkg::WIDTH,
    parameter int ADDR_W = regfile_pkg::ADDR_W
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [ADDR_W:0]   req_len;
    logic [ADDR_W-1:0] rf_addr;
    logic [WIDTH-1:0]  rf_data;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;
    logic [ADDR_W-1:0] out_idx;
    logic              out_last;
    logic              busy;

    // master is the engine, slave is the requester/consumer/register file side
    modport master (
        input  req_valid, req_addr, req_len, rf_data, out_ready,
        output req_ready, rf_addr, out_valid, out_data, out_idx, out_last, busy
    );

    modport slave (
        output req_valid, req_addr, req_len, rf_data, out_ready,
        input  req_ready, rf_addr, out_valid, out_data, out_idx, out_last, busy
    );

endinterface

// File: rtl/regfile_burst_reader_stream_out_stage.sv
// Output holding register: loads a beat, clears when the held beat is accepted
// and nothing new is loaded in the same cycle.
module stream_out_stage
    import regfile_pkg::*;
#(
    parameter int WIDTH  = regfile_pkg::WIDTH,
    parameter int ADDR_W = regfile_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              clr_i,
    input  logic [WIDTH-1:0]  data_i,
    input  logic [ADDR_W-1:0] idx_i,
    input  logic              last_i,
    output logic              valid_o,
    output logic [WIDTH-1:0]  data_o,
    output logic [ADDR_W-1:0] idx_o,
    output logic              last_o
);

    logic              valid_q;
    logic [WIDTH-1:0]  data_q;
    logic [ADDR_W-1:0] idx_q;
    logic              last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            idx_q   <= idx_i;
            last_q  <= last_i;
        end else if (valid_q && clr_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign idx_o   = idx_q;
    assign last_o  = last_q;

endmodule

// File: rtl/regfile_burst_reader.sv
// Burst read engine: walks len consecutive register-file addresses (wrapping)
// and streams the captured words through a valid/ready output register.
module regfile_burst_reader
    import regfile_pkg::*;
#(
    parameter int WIDTH  = regfile_pkg::WIDTH,
    parameter int ADDR_W = regfile_pkg::ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    regfile_burst_reader_if.master bus
);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_RUN   = ST_RUN;
    localparam logic [1:0] S_DRAIN = ST_DRAIN;

    localparam logic [ADDR_W-1:0] CUR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   LEN_ONE = (ADDR_W + 1)'(1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] cur_q, cur_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic              capture;

    logic              out_valid;
    logic [WIDTH-1:0]  out_data;
    logic [ADDR_W-1:0] out_idx;
    logic              out_last;

    // A beat is taken whenever the holding register is empty or being drained
    assign capture = (state_q == S_RUN) && (!out_valid || bus.out_ready);

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        rem_d   = rem_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid && (bus.req_len != '0)) begin
                    cur_d   = bus.req_addr;
                    rem_d   = bus.req_len;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (capture) begin
                    cur_d = cur_q + CUR_ONE;
                    rem_d = rem_q - LEN_ONE;
                    if (rem_q == LEN_ONE) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (out_valid && bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cur_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            rem_q   <= rem_d;
        end
    end

    stream_out_stage #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_out (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (capture),
        .clr_i   (bus.out_ready),
        .data_i  (bus.rf_data),
        .idx_i   (cur_q),
        .last_i  (rem_q == LEN_ONE),
        .valid_o (out_valid),
        .data_o  (out_data),
        .idx_o   (out_idx),
        .last_o  (out_last)
    );

    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.out_idx   = out_idx;
    assign bus.out_last  = out_last;

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign bus.rf_addr   = (state_q == S_IDLE) ? bus.req_addr : cur_q;

endmodule
